// File: rtl/req_scheduler.sv
// req_scheduler: latches cab and hall requests for one elevator car, clears
// them when the car is served, and runs the IDLE/UP/DOWN direction FSM that
// picks the next floor to serve.
module req_scheduler #(
  parameter int F_N = 4,   // number of floors (2..16)
  parameter int FW  = 8    // width of the binary floor index
) (
  input  logic           clk380hz,
  input  logic           rst,         // synchronous, active-low
  input  logic [FW-1:0]  curr_floor,
  input  logic           moving,
  input  logic           door_open,
  input  logic [F_N-1:0] floor_in,
  input  logic [F_N-1:0] up_in,
  input  logic [F_N-1:0] down_in,
  output logic [F_N-1:0] cab_pend,
  output logic [F_N-1:0] up_pend,
  output logic [F_N-1:0] down_pend,
  output logic [1:0]     dir,
  output logic [FW-1:0]  target,
  output logic           stop_here,
  output logic           any_pend
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_UP   = 2'b01,
    S_DOWN = 2'b10
  } dir_t;

  // The top floor has no up button and the bottom floor no down button.
  localparam logic [F_N-1:0] UP_OK   = ~(F_N'(1) << (F_N - 1));
  localparam logic [F_N-1:0] DOWN_OK = ~F_N'(1);

  dir_t           state_reg;
  logic [FW-1:0]  target_reg;
  logic [F_N-1:0] cab_reg, up_reg, down_reg;
  logic [F_N-1:0] floor_q_reg, up_q_reg, down_q_reg;

  logic [F_N-1:0] gt_mask, lt_mask, eq_mask;
  logic [F_N-1:0] all_pend;
  logic [F_N-1:0] cab_set, up_set, down_set;
  logic [F_N-1:0] cab_clr, up_clr, down_clr;
  logic [F_N-1:0] cab_next, up_next, down_next;
  logic           cf_valid, served;
  logic           above, below, at_cf, beyond;
  logic [FW-1:0]  up_idx, down_idx;

  // Per-floor position of each index relative to the car. An out-of-range
  // curr_floor leaves eq_mask empty, so nothing is cleared or stopped at.
  genvar gi;
  generate
    for (gi = 0; gi < F_N; gi++) begin : g_mask
      localparam logic [FW-1:0] IDX = FW'(gi);
      assign gt_mask[gi] = (IDX > curr_floor);
      assign lt_mask[gi] = (IDX < curr_floor);
      assign eq_mask[gi] = (IDX == curr_floor);
    end
  endgenerate

  assign cf_valid = (curr_floor < FW'(F_N));
  assign all_pend = cab_reg | up_reg | down_reg;
  assign above    = |(all_pend & gt_mask);
  assign below    = |(all_pend & lt_mask);
  assign at_cf    = |(all_pend & eq_mask);
  assign served   = door_open & ~moving & cf_valid;

  // Rising edges of the buttons; a held button only produces one edge.
  assign cab_set  = floor_in & ~floor_q_reg;
  assign up_set   = up_in & ~up_q_reg & UP_OK;
  assign down_set = down_in & ~down_q_reg & DOWN_OK;

  // Hall calls are cleared only for the direction the car is travelling.
  assign cab_clr  = served ? eq_mask : '0;
  assign up_clr   = (state_reg != S_DOWN) ? cab_clr : '0;
  assign down_clr = (state_reg != S_UP) ? cab_clr : '0;

  // Clear wins over a same-cycle capture of the same bit.
  assign cab_next  = (cab_reg | cab_set) & ~cab_clr;
  assign up_next   = (up_reg | up_set) & ~up_clr & UP_OK;
  assign down_next = (down_reg | down_set) & ~down_clr & DOWN_OK;

  // Nearest pending floor above and below the car; defaults to curr_floor.
  always_comb begin
    up_idx   = curr_floor;
    down_idx = curr_floor;
    for (int i = F_N - 1; i >= 0; i--) begin
      if (all_pend[i] && gt_mask[i]) up_idx = FW'(i);
    end
    for (int i = 0; i < F_N; i++) begin
      if (all_pend[i] && lt_mask[i]) down_idx = FW'(i);
    end
  end

  // Whether more work lies ahead in the travel direction.
  always_comb begin
    beyond = 1'b0;
    case (state_reg)
      S_UP:    beyond = above;
      S_DOWN:  beyond = below;
      default: beyond = 1'b0;
    endcase
  end

  assign stop_here = |(cab_reg & eq_mask)
                   | (|(up_reg & eq_mask) & (state_reg != S_DOWN))
                   | (|(down_reg & eq_mask) & (state_reg != S_UP))
                   | (at_cf & ~beyond);

  assign any_pend  = |all_pend;
  assign cab_pend  = cab_reg;
  assign up_pend   = up_reg;
  assign down_pend = down_reg;
  assign dir       = state_reg;
  assign target    = target_reg;

  // Button edge registers, request latches, direction FSM and target.
  always_ff @(posedge clk380hz) begin
    floor_q_reg <= floor_in;
    up_q_reg    <= up_in;
    down_q_reg  <= down_in;
    if (!rst) begin
      cab_reg    <= '0;
      up_reg     <= '0;
      down_reg   <= '0;
      state_reg  <= S_IDLE;
      target_reg <= '0;
    end else begin
      cab_reg  <= cab_next;
      up_reg   <= up_next;
      down_reg <= down_next;
      if (cf_valid) begin
        if (!moving) begin
          case (state_reg)
            S_DOWN: begin
              if (below) begin
                state_reg  <= S_DOWN;
                target_reg <= down_idx;
              end else if (above) begin
                state_reg  <= S_UP;
                target_reg <= up_idx;
              end else begin
                state_reg  <= S_IDLE;
                target_reg <= curr_floor;
              end
            end
            default: begin
              if (above) begin
                state_reg  <= S_UP;
                target_reg <= up_idx;
              end else if (below) begin
                state_reg  <= S_DOWN;
                target_reg <= down_idx;
              end else begin
                state_reg  <= S_IDLE;
                target_reg <= curr_floor;
              end
            end
          endcase
        end else begin
          case (state_reg)
            S_UP:    target_reg <= up_idx;
            S_DOWN:  target_reg <= down_idx;
            default: target_reg <= curr_floor;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_req_scheduler.sv
// tb_req_scheduler: directed vector table plus hand-written sequences for
// held buttons and buttons held through reset.
module tb_req_scheduler;

  localparam int F_N = 4;
  localparam int FW  = 8;

  logic           clk380hz = 1'b0;
  logic           rst;
  logic [FW-1:0]  curr_floor;
  logic           moving, door_open;
  logic [F_N-1:0] floor_in, up_in, down_in;
  logic [F_N-1:0] cab_pend, up_pend, down_pend;
  logic [1:0]     dir;
  logic [FW-1:0]  target;
  logic           stop_here, any_pend;

  int checks = 0;
  int errors = 0;

  always #5 clk380hz = ~clk380hz;

  req_scheduler #(.F_N(F_N), .FW(FW)) dut (
    .clk380hz  (clk380hz),
    .rst       (rst),
    .curr_floor(curr_floor),
    .moving    (moving),
    .door_open (door_open),
    .floor_in  (floor_in),
    .up_in     (up_in),
    .down_in   (down_in),
    .cab_pend  (cab_pend),
    .up_pend   (up_pend),
    .down_pend (down_pend),
    .dir       (dir),
    .target    (target),
    .stop_here (stop_here),
    .any_pend  (any_pend)
  );

  typedef struct {
    logic           rst;
    logic [FW-1:0]  cf;
    logic           mv;
    logic           door;
    logic [F_N-1:0] fl, up, dn;
    logic [F_N-1:0] e_cab, e_up, e_dn;
    logic [1:0]     e_dir;
    logic [FW-1:0]  e_tgt;
    logic           e_stop, e_any;
  } vec_t;

  vec_t tbl[40];
  int   n_vec = 0;

  task automatic add(input int r, input int cf, input int mv, input int dr,
                     input int fl, input int up, input int dn,
                     input int ecab, input int eup, input int edn,
                     input int edir, input int etgt, input int estop, input int eany);
    tbl[n_vec].rst    = 1'(r);
    tbl[n_vec].cf     = FW'(cf);
    tbl[n_vec].mv     = 1'(mv);
    tbl[n_vec].door   = 1'(dr);
    tbl[n_vec].fl     = F_N'(fl);
    tbl[n_vec].up     = F_N'(up);
    tbl[n_vec].dn     = F_N'(dn);
    tbl[n_vec].e_cab  = F_N'(ecab);
    tbl[n_vec].e_up   = F_N'(eup);
    tbl[n_vec].e_dn   = F_N'(edn);
    tbl[n_vec].e_dir  = 2'(edir);
    tbl[n_vec].e_tgt  = FW'(etgt);
    tbl[n_vec].e_stop = 1'(estop);
    tbl[n_vec].e_any  = 1'(eany);
    n_vec++;
  endtask

  task automatic chk(input string name, input int idx, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk380hz);
    #1;
  endtask

  initial begin
    rst = 1'b0; curr_floor = '0; moving = 1'b0; door_open = 1'b0;
    floor_in = '0; up_in = '0; down_in = '0;

    //  rst cf mv dr  fl      up      dn   | cab     up      dn     dir tgt stop any
    // hall-up press at floor 2 from idle at floor 0
    add(0, 0, 0, 0, 'b0000, 'b0000, 'b0000, 'b0000, 'b0000, 'b0000, 0, 0, 0, 0);
    add(1, 0, 0, 0, 'b0000, 'b0100, 'b0000, 'b0000, 'b0100, 'b0000, 0, 0, 0, 1);
    add(1, 0, 0, 0, 'b0000, 'b0000, 'b0000, 'b0000, 'b0100, 'b0000, 1, 2, 0, 1);
    // add down call at 1, travel to 2 and serve going up, then reverse
    add(1, 0, 0, 0, 'b0000, 'b0000, 'b0010, 'b0000, 'b0100, 'b0010, 1, 2, 0, 1);
    add(1, 0, 0, 0, 'b0000, 'b0000, 'b0000, 'b0000, 'b0100, 'b0010, 1, 1, 0, 1);
    add(1, 2, 1, 0, 'b0000, 'b0000, 'b0000, 'b0000, 'b0100, 'b0010, 1, 2, 1, 1);
    add(1, 2, 0, 1, 'b0000, 'b0000, 'b0000, 'b0000, 'b0000, 'b0010, 2, 1, 0, 1);
    // cab calls at 3 and 0 from floor 1: UP held while moving, DOWN at 3
    add(0, 1, 0, 0, 'b0000, 'b0000, 'b0000, 'b0000, 'b0000, 'b0000, 0, 0, 0, 0);
    add(1, 1, 0, 0, 'b1001, 'b0000, 'b0000, 'b1001, 'b0000, 'b0000, 0, 1, 0, 1);
    add(1, 1, 0, 0, 'b0000, 'b0000, 'b0000, 'b1001, 'b0000, 'b0000, 1, 3, 0, 1);
    add(1, 2, 1, 0, 'b0000, 'b0000, 'b0000, 'b1001, 'b0000, 'b0000, 1, 3, 0, 1);
    add(1, 3, 1, 0, 'b0000, 'b0000, 'b0000, 'b1001, 'b0000, 'b0000, 1, 3, 1, 1);
    add(1, 3, 0, 0, 'b0000, 'b0000, 'b0000, 'b1001, 'b0000, 'b0000, 2, 0, 1, 1);
    // nonexistent hall buttons (up at top, down at bottom) are ignored
    add(0, 0, 0, 0, 'b0000, 'b0000, 'b0000, 'b0000, 'b0000, 'b0000, 0, 0, 0, 0);
    add(1, 0, 0, 0, 'b0000, 'b1000, 'b0001, 'b0000, 'b0000, 'b0000, 0, 0, 0, 0);
    add(1, 0, 0, 0, 'b0000, 'b0000, 'b0000, 'b0000, 'b0000, 'b0000, 0, 0, 0, 0);
    // invalid floor index: no clear, dir and target hold, no stop
    add(1, 0, 0, 0, 'b0100, 'b0000, 'b0000, 'b0100, 'b0000, 'b0000, 0, 0, 0, 1);
    add(1, 0, 0, 0, 'b0000, 'b0000, 'b0000, 'b0100, 'b0000, 'b0000, 1, 2, 0, 1);
    add(1, 5, 0, 1, 'b0000, 'b0000, 'b0000, 'b0100, 'b0000, 'b0000, 1, 2, 0, 1);
    add(1, 2, 0, 1, 'b0000, 'b0000, 'b0000, 'b0000, 'b0000, 'b0000, 0, 2, 0, 0);
    // reset mid-travel discards requests and restarts in IDLE
    add(1, 0, 0, 0, 'b1000, 'b0000, 'b0000, 'b1000, 'b0000, 'b0000, 0, 0, 0, 1);
    add(1, 0, 0, 0, 'b0000, 'b0000, 'b0000, 'b1000, 'b0000, 'b0000, 1, 3, 0, 1);
    add(1, 1, 1, 0, 'b0000, 'b0000, 'b0000, 'b1000, 'b0000, 'b0000, 1, 3, 0, 1);
    add(0, 1, 1, 0, 'b0000, 'b0000, 'b0000, 'b0000, 'b0000, 'b0000, 0, 0, 0, 0);
    add(1, 1, 1, 0, 'b0000, 'b0000, 'b0000, 'b0000, 'b0000, 'b0000, 0, 1, 0, 0);
    // going DOWN to an up call with nothing below: stop, clear only when idle
    add(1, 3, 0, 0, 'b0000, 'b0010, 'b0000, 'b0000, 'b0010, 'b0000, 0, 3, 0, 1);
    add(1, 3, 0, 0, 'b0000, 'b0000, 'b0000, 'b0000, 'b0010, 'b0000, 2, 1, 0, 1);
    add(1, 1, 1, 0, 'b0000, 'b0000, 'b0000, 'b0000, 'b0010, 'b0000, 2, 1, 1, 1);
    add(1, 1, 0, 1, 'b0000, 'b0000, 'b0000, 'b0000, 'b0010, 'b0000, 0, 1, 1, 1);
    add(1, 1, 0, 1, 'b0000, 'b0000, 'b0000, 'b0000, 'b0000, 'b0000, 0, 1, 0, 0);

    for (int i = 0; i < n_vec; i++) begin
      rst        = tbl[i].rst;
      curr_floor = tbl[i].cf;
      moving     = tbl[i].mv;
      door_open  = tbl[i].door;
      floor_in   = tbl[i].fl;
      up_in      = tbl[i].up;
      down_in    = tbl[i].dn;
      tick();
      chk("cab_pend",  i, int'(cab_pend),  int'(tbl[i].e_cab));
      chk("up_pend",   i, int'(up_pend),   int'(tbl[i].e_up));
      chk("down_pend", i, int'(down_pend), int'(tbl[i].e_dn));
      chk("dir",       i, int'(dir),       int'(tbl[i].e_dir));
      chk("target",    i, int'(target),    int'(tbl[i].e_tgt));
      chk("stop_here", i, int'(stop_here), int'(tbl[i].e_stop));
      chk("any_pend",  i, int'(any_pend),  int'(tbl[i].e_any));
      $display("vec %0d rst=%0b cf=%0d mv=%0b door=%0b -> cab=%b up=%b dn=%b dir=%0d tgt=%0d stop=%0b any=%0b",
               i, rst, curr_floor, moving, door_open, cab_pend, up_pend, down_pend,
               dir, target, stop_here, any_pend);
    end

    // floor_in[3] held for five cycles: one capture, served mid-hold,
    // no recapture while still held, recaptured on a fresh press.
    begin
      logic [F_N-1:0] exp_hold [7];
      exp_hold = '{4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000};
      rst = 1'b1; moving = 1'b0;
      for (int c = 0; c < 7; c++) begin
        floor_in   = (c < 5 || c == 6) ? 4'b1000 : 4'b0000;
        curr_floor = (c == 2) ? 8'd3 : 8'd0;
        door_open  = (c == 2);
        tick();
        chk("hold_cab", c, int'(cab_pend), int'(exp_hold[c]));
        $display("hold %0d floor_in=%b cf=%0d door=%0b -> cab=%b",
                 c, floor_in, curr_floor, door_open, cab_pend);
      end
    end

    // floor_in[1] held through reset is not captured until pressed again.
    begin
      logic [F_N-1:0] exp_rst [7];
      exp_rst = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0010};
      curr_floor = 8'd0; door_open = 1'b0; moving = 1'b0;
      for (int c = 0; c < 7; c++) begin
        rst      = (c >= 2);
        floor_in = (c == 5) ? 4'b0000 : 4'b0010;
        tick();
        chk("rst_hold_cab", c, int'(cab_pend), int'(exp_rst[c]));
        $display("rsthold %0d rst=%0b floor_in=%b -> cab=%b", c, rst, floor_in, cab_pend);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/req_scheduler.md
REQ_SCHEDULER -- requirements
Module: req_scheduler

Interface
REQ-001 SHALL have parameter F_N, default 4, meaning number of floors (2..16).
REQ-002 SHALL have parameter FW, default 8, meaning width of the binary floor index.
REQ-003 SHALL have port clk380hz, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1; reset is synchronous and active-low.
REQ-005 SHALL have port curr_floor, input, FW, binary index of the car floor (0 = bottom).
REQ-006 SHALL have port moving, input, 1, high while the car travels between floors.
REQ-007 SHALL have port door_open, input, 1, high while the door is open.
REQ-008 SHALL have ports floor_in, up_in and down_in, input, F_N each: cab, hall-up and hall-down buttons (level).
REQ-009 SHALL have ports cab_pend, up_pend and down_pend, output, F_N each, holding the latched requests.
REQ-010 SHALL have port dir, output, 2, encoded 00 IDLE, 01 UP, 10 DOWN (11 never driven).
REQ-011 SHALL have port target, output, FW, the next floor to serve.
REQ-012 SHALL have port stop_here, output, 1, meaning the car must stop or open at curr_floor.
REQ-013 SHALL have port any_pend, output, 1, the OR of all pend bits.

Function
REQ-014 SHALL register each button bit every cycle and capture a request on a 0->1 edge, so a press first sampled high in cycle n sets its pend bit in cycle n+1.
REQ-015 SHALL hold a level-high button after its capture without retriggering, and SHALL ignore repeat edges on an already-pending bit.
REQ-016 SHALL tie up_pend[F_N-1] and down_pend[0] to 0 and ignore those buttons.
REQ-017 SHALL define "served" as door_open=1 and moving=0; in that condition it clears cab_pend[cf] next cycle.
REQ-018 SHALL, when served, also clear up_pend[cf] if dir=UP, down_pend[cf] if dir=DOWN, and both if dir=IDLE.
REQ-019 SHALL give clear priority over a same-cycle capture of the same bit.
REQ-020 SHALL treat curr_floor >= F_N as invalid: no clears, stop_here=0, and dir holds.
REQ-021 SHALL run the direction FSM {IDLE, UP, DOWN} with updates only while moving=0, where above/below means any pend bit at an index greater/less than cf.
REQ-022 SHALL move the FSM from IDLE to UP if above, else DOWN if below, else stay IDLE.
REQ-023 SHALL keep the FSM in UP if above, else go DOWN if below, else IDLE (DOWN is symmetric).
REQ-024 SHALL register target each cycle: in UP the lowest pend index > cf; in DOWN the highest pend index < cf; in IDLE, curr_floor.
REQ-025 SHALL drive stop_here combinationally from registered state as cab_pend[cf] | (up_pend[cf] & dir!=DOWN) | (down_pend[cf] & dir!=UP) | (any pend at cf & no pend beyond cf in dir).
REQ-026 SHALL drive any_pend combinationally from the pend registers.

Reset
REQ-027 SHALL, while rst=0 at a clock edge, clear all pend bits, set dir=IDLE, target=0 and stop_here=0.
REQ-028 SHALL, during reset, load the button edge registers with the current inputs, so buttons held through reset are not captured after release of rst.
REQ-029 SHALL, on reset asserted mid-travel, discard all requests; the FSM restarts from IDLE.

Verification
REQ-030 The bench SHALL cover: F_N=4, cf=0, idle, pulse up_in[2] -> up_pend=0100 next cycle, dir=UP next cycle, target=2.
REQ-031 The bench SHALL cover: cf=2, dir=UP, up_pend[2]=1, down_pend[1]=1, door_open=1, moving=0 -> up_pend[2] clears, then dir=DOWN, target=1.
REQ-032 The bench SHALL cover: cf=1, dir=UP, cab_pend=1000 and cab_pend[0] set, moving=1 -> dir stays UP until moving=0 at floor 3 with no pend above -> DOWN.
REQ-033 The bench SHALL cover: floor_in[3] held high across 5 cycles -> captured exactly once, and re-press after a clear recaptures.
REQ-034 The bench SHALL cover: up_in[3] and down_in[0] pressed -> no pend bits set, and any_pend=0.
REQ-035 The bench SHALL cover: rst=0 with floor_in[1] held, then rst=1 -> cab_pend=0000 until floor_in[1] falls and rises again.
